// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the pipeline front end.
//   word_t        : 32-bit datapath word (PCs, addresses, instructions)
//   PC_ALIGN_MASK : clears the byte-offset bits of a PC
//   fetch_state_t : fetch-stage FSM states
//   pc_sel_t      : next-PC source select used by pc_reg
//   align_pc()    : word-aligns an address
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam word_t PC_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        MISS   = 2'd1,
        DROP   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD  = 2'd0,
        PC_INC   = 2'd1,
        PC_REDIR = 2'd2,
        PC_PEND  = 2'd3
    } pc_sel_t;

    function automatic word_t align_pc(input word_t addr);
        return addr & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// Bundles the fetch stage's instruction-memory port, hazard/control inputs and
// IF/ID latch outputs.
//   imem   : ihit, imemload (in to fetch), imemREN, imemaddr (out of fetch)
//   ctrl   : stall, redirect, redirect_pc, halt (in to fetch)
//   IF/ID  : pcplus4_in, instr_in, ifid_wen, ifid_flush (out of fetch)
//   perf   : fetch_cnt, miss_cyc (out of fetch, only with FETCH_PERF_EN)
// Modports: master = fetch stage, slave = surrounding pipeline / memory.
// Optional feature macro: FETCH_PERF_EN
// -----------------------------------------------------------------------------
interface fetch_stage_if;
    import cpu_types_pkg::*;

    logic  ihit;
    word_t imemload;
    logic  imemREN;
    word_t imemaddr;
    logic  stall;
    logic  redirect;
    word_t redirect_pc;
    logic  halt;
    word_t pcplus4_in;
    word_t instr_in;
    logic  ifid_wen;
    logic  ifid_flush;
`ifdef FETCH_PERF_EN
    word_t fetch_cnt;
    word_t miss_cyc;
`endif

    modport master (
        input  ihit, imemload, stall, redirect, redirect_pc, halt,
        output imemREN, imemaddr, pcplus4_in, instr_in, ifid_wen, ifid_flush
`ifdef FETCH_PERF_EN
        , output fetch_cnt, miss_cyc
`endif
    );

    modport slave (
        output ihit, imemload, stall, redirect, redirect_pc, halt,
        input  imemREN, imemaddr, pcplus4_in, instr_in, ifid_wen, ifid_flush
`ifdef FETCH_PERF_EN
        , input fetch_cnt, miss_cyc
`endif
    );

endinterface

// File: rtl/fetch_stage_pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
// Program counter register with next-PC mux.
//   CLK, nRST     : clock, async active-low reset (loads PC_INIT)
//   sel_i         : next-PC source (hold / +4 / redirect / pending redirect)
//   redirect_pc_i : already word-aligned redirect target
//   pend_pc_i     : already word-aligned deferred redirect target
//   pc_o          : current PC
//   pcplus4_o     : current PC + 4 (wraps modulo 2^PC_W)
// -----------------------------------------------------------------------------
module pc_reg
    import cpu_types_pkg::*;
#(
    parameter int              PC_W    = 32,
    parameter logic [PC_W-1:0] PC_INIT = '0
) (
    input  logic            CLK,
    input  logic            nRST,
    input  pc_sel_t         sel_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    input  logic [PC_W-1:0] pend_pc_i,
    output logic [PC_W-1:0] pc_o,
    output logic [PC_W-1:0] pcplus4_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // Addition wraps naturally: 32'hFFFFFFFC + 4 -> 0.
    assign pcplus4_o = pc_q + PC_W'(4);
    assign pc_o      = pc_q;

    always_comb begin
        unique case (sel_i)
            PC_INC:   pc_d = pcplus4_o;
            PC_REDIR: pc_d = redirect_pc_i;
            PC_PEND:  pc_d = pend_pc_i;
            default:  pc_d = pc_q;
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of its peers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) pc_q <= PC_INIT;
        else       pc_q <= pc_d;
    end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the PC, drives the instruction-memory request,
// and resolves redirects, stalls and halt so the IF/ID latch only sees clean
// write/flush strobes.
//   CLK, nRST : clock, async active-low reset (all bus outputs forced to 0
//               while in reset)
//   bus       : fetch_stage_if.master (imem port, stall/redirect/halt inputs,
//               IF/ID outputs, optional perf counters)
// Parameters: PC_INIT (reset PC), PC_W (PC width, equals word_t width).
// Optional feature macro: FETCH_PERF_EN adds saturating fetch_cnt / miss_cyc.
// -----------------------------------------------------------------------------
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000,
    parameter int    PC_W    = 32
) (
    input  logic          CLK,
    input  logic          nRST,
    fetch_stage_if.master bus
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pend_pc_q, pend_pc_d;
    logic [PC_W-1:0] pc, pcplus4;
    logic [PC_W-1:0] redir_tgt;
    pc_sel_t         pc_sel;
    logic            ren, wen, flush;

    assign redir_tgt = align_pc(bus.redirect_pc);

    pc_reg #(
        .PC_W    (PC_W),
        .PC_INIT (PC_INIT)
    ) u_pc_reg (
        .CLK           (CLK),
        .nRST          (nRST),
        .sel_i         (pc_sel),
        .redirect_pc_i (redir_tgt),
        .pend_pc_i     (pend_pc_q),
        .pc_o          (pc),
        .pcplus4_o     (pcplus4)
    );

    // The PC only moves on ihit, so holding it through MISS/DROP keeps
    // imemaddr locked while a request is outstanding.
    // NOTE: every signal driven here gets a default first so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        pend_pc_d = pend_pc_q;
        pc_sel    = PC_HOLD;
        ren       = 1'b0;
        wen       = 1'b0;
        flush     = 1'b0;

        unique case (state_q)
            FETCH, MISS: begin
                ren = 1'b1;
                if (bus.halt) begin
                    state_d = HALTED;
                end else if (bus.redirect && bus.ihit) begin
                    pc_sel  = PC_REDIR;
                    flush   = 1'b1;
                    state_d = FETCH;
                end else if (bus.redirect) begin
                    // Wrong-path request still in flight: remember the target
                    // and swallow the data when it arrives.
                    pend_pc_d = redir_tgt;
                    flush     = 1'b1;
                    state_d   = DROP;
                end else if (bus.ihit) begin
                    state_d = FETCH;
                    if (!bus.stall) begin
                        wen    = 1'b1;
                        pc_sel = PC_INC;
                    end
                end else begin
                    state_d = MISS;
                end
            end

            DROP: begin
                ren = 1'b1;
                if (bus.halt) begin
                    state_d = HALTED;
                end else if (bus.redirect && bus.ihit) begin
                    pc_sel  = PC_REDIR;
                    flush   = 1'b1;
                    state_d = FETCH;
                end else if (bus.redirect) begin
                    pend_pc_d = redir_tgt;
                    flush     = 1'b1;
                end else if (bus.ihit) begin
                    pc_sel  = PC_PEND;
                    state_d = FETCH;
                end
            end

            default: begin
                // HALTED: frozen until reset.
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= FETCH;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    // Outputs are gated by nRST so the whole bus reads 0 during reset,
    // regardless of PC_INIT or what memory presents.
    assign bus.imemREN    = nRST & ren;
    assign bus.imemaddr   = nRST ? align_pc(word_t'(pc)) : '0;
    assign bus.pcplus4_in = nRST ? word_t'(pcplus4) : '0;
    assign bus.instr_in   = nRST ? bus.imemload : '0;
    assign bus.ifid_wen   = nRST & wen;
    assign bus.ifid_flush = nRST & flush;

`ifdef FETCH_PERF_EN
    word_t fetch_cnt_q, miss_cyc_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_cnt_q <= '0;
            miss_cyc_q  <= '0;
        end else if (state_q != HALTED) begin
            if (wen && (fetch_cnt_q != '1))
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (ren && !bus.ihit && (miss_cyc_q != '1))
                miss_cyc_q <= miss_cyc_q + 32'd1;
        end
    end

    assign bus.fetch_cnt = fetch_cnt_q;
    assign bus.miss_cyc  = miss_cyc_q;
`endif

endmodule
